// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : instruction_fetch_unit                                          |
// | Brief    : PC owner and fetch queue between instruction memory and decode. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module instruction_fetch_unit #(
  parameter logic [63:0] PC_RESET = 64'h0,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] Inst_Address,
  input  logic [31:0] Instruction,
  input  logic        Branch_Taken,
  input  logic [63:0] Branch_Target,
  output logic        Fetch_Valid,
  input  logic        Decode_Ready,
  output logic [31:0] Fetch_Instruction,
  output logic [63:0] Fetch_PC,
  output logic        Halted
);

  localparam int          AW      = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] c_depth = (AW + 1)'(DEPTH);
  localparam logic [0:0]  RUN     = 1'b0;
  localparam logic [0:0]  HALT    = 1'b1;

  logic [0:0]    r_state, w_state_nxt;
  logic [63:0]   r_pc;
  logic [31:0]   r_q_inst [DEPTH];
  logic [63:0]   r_q_pc   [DEPTH];
  logic [AW-1:0] r_head, r_tail;
  logic [AW:0]   r_count;

  logic w_pop, w_room, w_push, w_zero_stop;

  assign w_pop       = (r_count != '0) && Decode_Ready;
  assign w_room      = (r_count < c_depth) || w_pop;
  assign w_push      = (r_state == RUN) && w_room && (Instruction != 32'h0) && !Branch_Taken;
  assign w_zero_stop = (r_state == RUN) && w_room && (Instruction == 32'h0);

  assign Inst_Address      = r_pc;
  assign Fetch_Valid       = (r_count != '0);
  assign Fetch_Instruction = Fetch_Valid ? r_q_inst[r_head] : 32'h0;
  assign Fetch_PC          = Fetch_Valid ? r_q_pc[r_head]   : 64'h0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (Branch_Taken)     w_state_nxt = RUN;
    else if (w_zero_stop) w_state_nxt = HALT;
  end

  always_comb begin
    Halted = (r_state == HALT);
  end

  // A redirect discards that edge's push and pop along with the queued words.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc    <= PC_RESET;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q_inst[i] <= 32'h0;
        r_q_pc[i]   <= 64'h0;
      end
    end else if (Branch_Taken) begin
      r_pc    <= Branch_Target & ~64'h3;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_q_inst[r_tail] <= Instruction;
        r_q_pc[r_tail]   <= r_pc;
        r_tail           <= r_tail + 1'b1;
        r_pc             <= r_pc + 64'd4;
      end
      if (w_pop) r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_instruction_fetch_unit                                       |
// | Brief    : Scoreboard bench for instruction_fetch_unit with a memory model.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] Inst_Address;
  logic [31:0] Instruction;
  logic        Branch_Taken = 1'b0;
  logic [63:0] Branch_Target = 64'h0;
  logic        Fetch_Valid;
  logic        Decode_Ready = 1'b0;
  logic [31:0] Fetch_Instruction;
  logic [63:0] Fetch_PC;
  logic        Halted;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic fill_mode = 1'b0;
  logic [7:0] prog [8] = '{8'h83, 8'h34, 8'h85, 8'h02, 8'h33, 8'h84, 8'h8A, 8'h00};

  instruction_fetch_unit #(.PC_RESET(64'h0), .DEPTH(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .Inst_Address      (Inst_Address),
    .Instruction       (Instruction),
    .Branch_Taken      (Branch_Taken),
    .Branch_Target     (Branch_Target),
    .Fetch_Valid       (Fetch_Valid),
    .Decode_Ready      (Decode_Ready),
    .Fetch_Instruction (Fetch_Instruction),
    .Fetch_PC          (Fetch_PC),
    .Halted            (Halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] w;
    w = 32'h0;
    if (fill_mode) w = 32'hA500_0000 | {8'h00, a[23:0]};
    else begin
      for (int b = 0; b < 4; b++)
        if (a + 64'(b) < 64'd8) w[8*b +: 8] = prog[a[2:0] + 3'(b)];
    end
    return w;
  endfunction

  always_comb Instruction = mem_word(Inst_Address);

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Each accepted handshake is matched against the next expected word.
  always @(negedge clk) begin
    if (reset && !Branch_Taken && Fetch_Valid && Decode_Ready) begin
      if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("fetch_pc", Fetch_PC, e.pc);
        chk("fetch_inst", {32'h0, Fetch_Instruction}, {32'h0, e.inst});
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ready);
    reset = 1'b0;
    Branch_Taken = 1'b0;
    Decode_Ready = ready;
    sb.delete();
    cycles(2);
    reset = 1'b1;
  endtask

  task automatic push_exp(input logic [63:0] pc);
    exp_t e;
    e.pc = pc;
    e.inst = mem_word(pc);
    sb.push_back(e);
  endtask

  initial begin
    // Reset state
    reset = 1'b0;
    #12;
    chk("rst_valid", {63'h0, Fetch_Valid}, 64'd0);
    chk("rst_halted", {63'h0, Halted}, 64'd0);
    chk("rst_pc", Fetch_PC, 64'd0);
    chk("rst_inst", {32'h0, Fetch_Instruction}, 64'd0);
    chk("rst_addr", Inst_Address, 64'd0);

    // Test 1: straight-line fetch, halt on zero word
    do_reset(1'b1);
    push_exp(64'd0);
    push_exp(64'd4);
    chk("t1_addr0", Inst_Address, 64'd0);
    chk("t1_inst0", {32'h0, Instruction}, 64'h0285_3483);
    cycles(1);
    chk("t1_valid", {63'h0, Fetch_Valid}, 64'd1);
    cycles(5);
    chk("t1_addr8", Inst_Address, 64'd8);
    chk("t1_halted", {63'h0, Halted}, 64'd1);
    chk("t1_drained", {63'h0, Fetch_Valid}, 64'd0);
    chk("t1_empty_inst", {32'h0, Fetch_Instruction}, 64'd0);
    chk("t1_sb_empty", 64'(sb.size()), 64'd0);

    // Test 2: back-pressure fills the queue, then drains in order
    do_reset(1'b0);
    cycles(4);
    chk("t2_addr", Inst_Address, 64'd8);
    chk("t2_no_halt", {63'h0, Halted}, 64'd0);
    chk("t2_head_pc", Fetch_PC, 64'd0);
    push_exp(64'd0);
    push_exp(64'd4);
    Decode_Ready = 1'b1;
    cycles(4);
    chk("t2_halted", {63'h0, Halted}, 64'd1);
    chk("t2_sb_empty", 64'(sb.size()), 64'd0);

    // Test 3: redirect out of HALT
    Branch_Taken = 1'b1;
    Branch_Target = 64'h4;
    cycles(1);
    Branch_Taken = 1'b0;
    push_exp(64'd4);
    chk("t3_unhalt", {63'h0, Halted}, 64'd0);
    chk("t3_bubble", {63'h0, Fetch_Valid}, 64'd0);
    cycles(1);
    chk("t3_valid", {63'h0, Fetch_Valid}, 64'd1);
    chk("t3_head_pc", Fetch_PC, 64'd4);
    cycles(3);
    chk("t3_sb_empty", 64'(sb.size()), 64'd0);

    // Test 4: redirect flushes a full queue; target low bits cleared
    do_reset(1'b0);
    cycles(4);
    Decode_Ready = 1'b1;
    Branch_Taken = 1'b1;
    Branch_Target = 64'h7;
    cycles(1);
    Branch_Taken = 1'b0;
    chk("t4_flush", {63'h0, Fetch_Valid}, 64'd0);
    chk("t4_addr", Inst_Address, 64'd4);
    push_exp(64'd4);
    cycles(4);
    chk("t4_sb_empty", 64'(sb.size()), 64'd0);

    // Test 5: asynchronous reset between edges
    do_reset(1'b0);
    cycles(2);
    chk("t5_pre_valid", {63'h0, Fetch_Valid}, 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("t5_valid", {63'h0, Fetch_Valid}, 64'd0);
    chk("t5_halted", {63'h0, Halted}, 64'd0);
    chk("t5_pc", Fetch_PC, 64'd0);
    chk("t5_inst", {32'h0, Fetch_Instruction}, 64'd0);
    chk("t5_addr", Inst_Address, 64'd0);

    // Test 6: full queue with simultaneous push and pop
    fill_mode = 1'b1;
    do_reset(1'b0);
    cycles(4);
    for (int k = 0; k < 8; k++) push_exp(64'(4 * k));
    Decode_Ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycles(1);
      if (k == 3) chk("t6_valid", {63'h0, Fetch_Valid}, 64'd1);
    end
    Decode_Ready = 1'b0;
    chk("t6_sb_empty", 64'(sb.size()), 64'd0);
    chk("t6_head_pc", Fetch_PC, 64'd32);
    chk("t6_addr", Inst_Address, 64'd40);
    cycles(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
